skew_feeder: RTL
================

Name: skew_feeder

Overview:
- Sits between the byte-wide ready/valid input stream (SIPO output) and the systolic_array data inputs.
- Buffers one operand matrix A (array_height_p x depth_p) and one operand matrix B (depth_p x array_width_p), both received row-major.
- Once both are loaded, streams them into the array edges with the diagonal skew the MAC grid needs: row r is delayed r cycles, column c is delayed c cycles.
- The stream advances only while the array enable is high.

Parameters:
- width_p, 8: bits per matrix element.
- array_height_p, 2: rows of A; number of row feed lanes.
- array_width_p, 2: columns of B; number of column feed lanes.
- depth_p, 2: inner dimension (columns of A, rows of B).

Ports:
- clk_i  in  1  system clock.
- reset_n_i  in  1  synchronous reset, active-low.
- valid_i  in  1  input element valid.
- data_i  in  width_p  input element.
- ready_o  out  1  feeder can accept an element.
- en_i  in  1  array advance enable; the stream holds when low.
- row_data_o  out  array_height_p*width_p  lane r at [r*width_p +: width_p].
- row_valid_o  out  array_height_p  per-row lane valid.
- col_data_o  out  array_width_p*width_p  lane c at [c*width_p +: width_p].
- col_valid_o  out  array_width_p  per-column lane valid.
- busy_o  out  1  high in STREAM.
- done_o  out  1  single-cycle pulse after the last stream step.

Behaviour:
- Reset is synchronous, active-low: reset_n_i==0 sampled at posedge clk_i.
  - Values at reset: state=LOAD_A, element counter=0, stream counter t=0.
  - Outputs at reset: ready_o=1, all valid outputs 0, all data outputs 0, busy_o=0, done_o=0.
  - Buffer contents need not be cleared.
- Reset mid-load or mid-stream discards the partial matrices and all progress.
- Input handshake:
  - A transfer occurs on a cycle where valid_i & ready_o.
  - ready_o = 1 only in LOAD_A/LOAD_B; it is combinational from state only, never from valid_i.
- LOAD_A:
  - Element k is written to A[k / depth_p][k % depth_p].
  - After element array_height_p*depth_p-1 is accepted, go to LOAD_B with the counter cleared.
- LOAD_B:
  - Element k is written to B[k / array_width_p][k % array_width_p].
  - After element depth_p*array_width_p-1 is accepted, go to STREAM with t=0.
- STREAM:
  - ready_o=0 and busy_o=1.
  - Outputs are registered and reflect the current t.
  - Row lane r: valid iff 0 <= t-r < depth_p; data = A[r][t-r] when valid, 0 otherwise.
  - Column lane c: valid iff 0 <= t-c < depth_p; data = B[t-c][c] when valid, 0 otherwise.
  - t advances by 1 only on cycles with en_i=1. With en_i=0, all outputs and t hold.
  - Last step is T_last = depth_p + max(array_height_p, array_width_p) - 2.
  - On an en_i=1 cycle at t=T_last:
    - next state is LOAD_A;
    - counters clear;
    - done_o pulses high for exactly the following cycle;
    - all valid outputs drop to 0 that same cycle.
- Latency: the first stream beat (t=0) is presented on the cycle after the final B element handshake.
- Boundary cases:
  - valid_i asserted in STREAM is ignored; no data is consumed.
  - en_i is ignored outside STREAM.
  - A new A load may be handshaken on the same cycle done_o is high, because ready_o=1 in LOAD_A.
  - Counter widths are sized with $clog2 and must cover depth_p=1 and non-square arrays.

Test Plan:
1. Reset: hold reset_n_i=0 for 3 cycles with valid_i=1 -> ready_o=1, row_valid_o=0, col_valid_o=0, busy_o=0, done_o=0; no element counted.
2. Nominal 2x2 load and stream:
   - Stimulus: stream 1,2,3,4 then 5,6,7,8; hold en_i=1.
   - t0: row=(1,-), col=(5,-).
   - t1: row=(2,3), col=(7,6).
   - t2: row=(-,4), col=(-,8).
   - Next cycle: done_o=1, valids=0, ready_o=1.
3. Stall: same stimulus, with en_i=0 for 4 cycles at t1 -> outputs hold (2,3)/(7,6) for the whole stall; done_o arrives 4 cycles later than in scenario 2.
4. Backpressure: drive valid_i=1 continuously with values 9,10,... during STREAM -> ready_o=0 and nothing is captured; the next A load starts with the first value presented after done_o.
5. Reset mid-stream: assert reset_n_i=0 at t1 -> next cycle all valids are 0 and state is LOAD_A; reloading 1..8 reproduces scenario 2 exactly.
6. Non-square configuration (array_height_p=3, array_width_p=2, depth_p=2):
   - Stimulus: A=1..6, B=7..10.
   - T_last=3.
   - row2 valid at t2 (5) and t3 (6).
   - col1 valid at t1 (8) and t2 (10).
   - done_o pulses after t3.

Source files
------------

// File: rtl/skew_feeder.sv
// skew_feeder: buffers one A and one B operand matrix from a byte stream and
// feeds them into the systolic array edges with a per-lane diagonal skew.
module skew_feeder #(
  parameter int width_p        = 8,
  parameter int array_height_p = 2,
  parameter int array_width_p  = 2,
  parameter int depth_p        = 2
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              valid_i,
  input  logic [width_p-1:0]                data_i,
  output logic                              ready_o,
  input  logic                              en_i,
  output logic [array_height_p*width_p-1:0] row_data_o,
  output logic [array_height_p-1:0]         row_valid_o,
  output logic [array_width_p*width_p-1:0]  col_data_o,
  output logic [array_width_p-1:0]          col_valid_o,
  output logic                              busy_o,
  output logic                              done_o
);
  localparam int H  = array_height_p;
  localparam int W  = array_width_p;
  localparam int D  = depth_p;
  localparam int TL = D + (H > W ? H : W) - 2;
  localparam int IM = H > D ? H : D;
  localparam int JM = D > W ? D : W;
  localparam int IW = IM > 1 ? $clog2(IM) : 1;
  localparam int JW = JM > 1 ? $clog2(JM) : 1;
  localparam int TW = TL > 0 ? $clog2(TL + 1) : 1;
  typedef enum logic [1:0] {LOAD_A, LOAD_B, STREAM} state_t;
  state_t st, st_n;
  logic [IW-1:0] i, i_n;
  logic [JW-1:0] j, j_n;
  logic [TW-1:0] t, t_n;
  logic [width_p-1:0] a [H][D];
  logic [width_p-1:0] a_n [H][D];
  logic [width_p-1:0] b [D][W];
  logic [width_p-1:0] b_n [D][W];
  logic [H*width_p-1:0] rd_n;
  logic [H-1:0] rv_n;
  logic [W*width_p-1:0] cd_n;
  logic [W-1:0] cv_n;
  logic done_n, il, jl;
  int dl;
  assign ready_o = st != STREAM;
  assign busy_o  = st == STREAM;
  // Outputs are built from the next t and the buffer contents including this
  // cycle's write, so the first beat can use the element just handshaken.
  always_comb begin
    st_n = st;
    i_n = i;
    j_n = j;
    t_n = t;
    a_n = a;
    b_n = b;
    done_n = 1'b0;
    rd_n = '0;
    rv_n = '0;
    cd_n = '0;
    cv_n = '0;
    dl = 0;
    jl = j == (st == LOAD_A ? JW'(D - 1) : JW'(W - 1));
    il = i == (st == LOAD_A ? IW'(H - 1) : IW'(D - 1));
    if (st != STREAM && valid_i) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < D; c++)
          if (st == LOAD_A && i == IW'(r) && j == JW'(c)) a_n[r][c] = data_i;
      for (int r = 0; r < D; r++)
        for (int c = 0; c < W; c++)
          if (st == LOAD_B && i == IW'(r) && j == JW'(c)) b_n[r][c] = data_i;
      j_n = jl ? '0 : j + JW'(1);
      i_n = jl ? (il ? '0 : i + IW'(1)) : i;
      if (jl && il) st_n = st == LOAD_A ? LOAD_B : STREAM;
    end else if (st == STREAM && en_i) begin
      t_n = t == TW'(TL) ? '0 : t + TW'(1);
      if (t == TW'(TL)) begin
        st_n = LOAD_A;
        done_n = 1'b1;
      end
    end
    for (int r = 0; r < H; r++) begin
      dl = int'(t_n) - r;
      for (int k = 0; k < D; k++)
        if (st_n == STREAM && dl == k) begin
          rv_n[r] = 1'b1;
          rd_n[r*width_p +: width_p] = a_n[r][k];
        end
    end
    for (int c = 0; c < W; c++) begin
      dl = int'(t_n) - c;
      for (int k = 0; k < D; k++)
        if (st_n == STREAM && dl == k) begin
          cv_n[c] = 1'b1;
          cd_n[c*width_p +: width_p] = b_n[k][c];
        end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      st <= LOAD_A;
      i <= '0;
      j <= '0;
      t <= '0;
      row_data_o <= '0;
      row_valid_o <= '0;
      col_data_o <= '0;
      col_valid_o <= '0;
      done_o <= 1'b0;
    end else begin
      st <= st_n;
      i <= i_n;
      j <= j_n;
      t <= t_n;
      row_data_o <= rd_n;
      row_valid_o <= rv_n;
      col_data_o <= cd_n;
      col_valid_o <= cv_n;
      done_o <= done_n;
    end
  end
  always_ff @(posedge clk_i) begin
    a <= a_n;
    b <= b_n;
  end
endmodule
